// File: rtl/adc_seq_sched.sv
// adc_seq_sched: channel scheduler for an 8-channel AD7928 serial ADC frame engine.
// Posts per-channel requests (edge-triggered or from the periodic auto-scan),
// grants them round-robin, issues one frame at a time, and routes each result
// back one frame later to match the converter's one-frame address pipeline.
// Optional build macro ADC_SEQ_SCHED_TAG_CHECK_EN: verify the returned address
// tag against the expected channel; on mismatch raise err and retry the channel.
module adc_seq_sched #(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned CW       = 12,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    input  logic            scan_en,
    input  logic [N_CH-1:0] scan_mask,
    output logic            frm_start,
    output logic [2:0]      frm_addr,
    input  logic            frm_busy,
    input  logic            frm_done,
    input  logic [15:0]     frm_data,
    output logic            res_vld,
    output logic [2:0]      res_ch,
    output logic [CW-1:0]   res_data,
    output logic [N_CH-1:0] ack,
    output logic            busy,
    output logic            err,
    input  logic            err_clr
);

    localparam int unsigned TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t          state_q;
    logic [N_CH-1:0] req_q;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] pend_set, pend_clr;
    logic [TW-1:0]   tmr_q;
    logic            tick;
    logic [2:0]      rr_q;
    logic [2:0]      sel;
    logic [2:0]      idx;
    logic            found;
    logic [2:0]      cur_addr_q;
    logic            cur_real_q;
    logic [2:0]      prev_addr_q;
    logic            prev_valid_q;
    logic            frm_start_q;
    logic [2:0]      frm_addr_q;
    logic            res_vld_q;
    logic [2:0]      res_ch_q;
    logic [CW-1:0]   res_data_q;
    logic [N_CH-1:0] ack_q;
    logic            issue_real, issue_flush;
    logic            done_ok, take_res, tag_bad, res_ok;
    logic            unused_in;

    // Issue/completion qualifiers; a done coincident with our own start pulse is stale.
    assign issue_real  = (state_q == IDLE) && !frm_busy && (pend_q != '0);
    assign issue_flush = (state_q == IDLE) && !frm_busy && (pend_q == '0) && prev_valid_q;
    assign done_ok     = (state_q == WAIT) && frm_done && !frm_start_q;
    assign take_res    = done_ok && prev_valid_q;
    assign res_ok      = take_res && !tag_bad;

`ifdef ADC_SEQ_SCHED_TAG_CHECK_EN
    logic err_q;

    assign tag_bad   = take_res && (frm_data[14:12] != prev_addr_q);
    assign err       = err_q;
    assign unused_in = frm_data[15];

    // Sticky error flag; a new tag mismatch outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (tag_bad) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end
`else
    assign tag_bad   = 1'b0;
    assign err       = 1'b0;
    assign unused_in = ^{frm_data[15:12], err_clr};
`endif

    // Auto-scan timer: free-runs 0..SCAN_DIV-1 while enabled, ticks on wrap.
    assign tick = scan_en && (tmr_q == TW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else if (!scan_en || tick) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + 1'b1;
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        sel   = rr_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = rr_q + 3'(k);
            if (!found && pend_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Pending set: sets (edges, scan, retry) take priority over the grant clear.
    always_comb begin
        pend_set = req & ~req_q;
        if (tick) begin
            pend_set = pend_set | scan_mask;
        end
        if (tag_bad) begin
            pend_set[prev_addr_q] = 1'b1;
        end
        pend_clr = '0;
        if (issue_real) begin
            pend_clr[sel] = 1'b1;
        end
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    // Request edge detector and pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            pend_q <= '0;
        end else begin
            req_q  <= req;
            pend_q <= pend_d;
        end
    end

    // Frame FSM: issues frames, tracks the one-frame pipeline, emits results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= 3'd7;
            cur_addr_q   <= '0;
            cur_real_q   <= 1'b0;
            prev_addr_q  <= '0;
            prev_valid_q <= 1'b0;
            frm_start_q  <= 1'b0;
            frm_addr_q   <= '0;
            res_vld_q    <= 1'b0;
            res_ch_q     <= '0;
            res_data_q   <= '0;
            ack_q        <= '0;
        end else begin
            frm_start_q <= 1'b0;
            res_vld_q   <= 1'b0;
            ack_q       <= '0;
            case (state_q)
                IDLE: begin
                    if (issue_real) begin
                        frm_start_q <= 1'b1;
                        frm_addr_q  <= sel;
                        cur_addr_q  <= sel;
                        cur_real_q  <= 1'b1;
                        rr_q        <= sel;
                        state_q     <= WAIT;
                    end else if (issue_flush) begin
                        frm_start_q <= 1'b1;
                        frm_addr_q  <= prev_addr_q;
                        cur_addr_q  <= prev_addr_q;
                        cur_real_q  <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (done_ok) begin
                        if (res_ok) begin
                            res_vld_q  <= 1'b1;
                            res_ch_q   <= prev_addr_q;
                            res_data_q <= frm_data[CW-1:0];
                            ack_q      <= N_CH'(1) << prev_addr_q;
                        end
                        prev_addr_q  <= cur_addr_q;
                        prev_valid_q <= cur_real_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign frm_start = frm_start_q;
    assign frm_addr  = frm_addr_q;
    assign res_vld   = res_vld_q;
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;
    assign ack       = ack_q;
    assign busy      = (state_q != IDLE) | prev_valid_q | (pend_q != '0);

endmodule

// File: tb/tb_adc_seq_sched.sv
// Scoreboard bench for adc_seq_sched with a behavioural AD7928 frame engine.
module tb_adc_seq_sched;

    localparam int unsigned FRAME_LEN = 4;
    localparam logic [11:0] VAL [8] = '{12'h123, 12'h456, 12'h789, 12'hABC,
                                        12'hDEF, 12'h0F0, 12'h5A5, 12'hFED};

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] d;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  req;
    logic        scan_en;
    logic [7:0]  scan_mask;
    logic        frm_start;
    logic [2:0]  frm_addr;
    logic        frm_busy;
    logic        frm_done;
    logic [15:0] frm_data;
    logic        res_vld;
    logic [2:0]  res_ch;
    logic [11:0] res_data;
    logic [7:0]  ack;
    logic        busy;
    logic        err;
    logic        err_clr;

    int n_vec = 0;
    int n_bad = 0;

    logic [2:0] exp_iss[$];
    res_t       exp_res[$];

    // engine model state
    bit         eng_act;
    int         eng_cnt;
    logic [2:0] cur_ch, last_ch, tag;
    int         start_no, done_no;
    int         glitch_at, corrupt_at;

    adc_seq_sched #(.N_CH(8), .CW(12), .SCAN_DIV(100)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .scan_en(scan_en), .scan_mask(scan_mask),
        .frm_start(frm_start), .frm_addr(frm_addr), .frm_busy(frm_busy),
        .frm_done(frm_done), .frm_data(frm_data), .res_vld(res_vld), .res_ch(res_ch),
        .res_data(res_data), .ack(ack), .busy(busy), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_res(input logic [2:0] ch);
        res_t r;
        r.ch = ch;
        r.d  = VAL[ch];
        exp_res.push_back(r);
    endtask

    task automatic pulse_req(input logic [7:0] m);
        @(negedge clk);
        req = m;
        @(negedge clk);
        req = '0;
    endtask

    task automatic wait_start(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!frm_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_start_timeout"}, 32'(n >= 200), 32'd0);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((exp_iss.size() != 0 || exp_res.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain_timeout"}, 32'(n >= 1000), 32'd0);
        repeat (10) @(negedge clk);
        chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; scan_en = 1'b0; scan_mask = '0; err_clr = 1'b0;
        glitch_at = 0; corrupt_at = 0;
        repeat (3) @(negedge clk);
        chk({nm, "_rst_frm_start"}, 32'(frm_start), 32'd0);
        chk({nm, "_rst_frm_addr"}, 32'(frm_addr), 32'd0);
        chk({nm, "_rst_res_vld"}, 32'(res_vld), 32'd0);
        chk({nm, "_rst_res_ch"}, 32'(res_ch), 32'd0);
        chk({nm, "_rst_res_data"}, 32'(res_data), 32'd0);
        chk({nm, "_rst_ack"}, 32'(ack), 32'd0);
        chk({nm, "_rst_busy"}, 32'(busy), 32'd0);
        chk({nm, "_rst_err"}, 32'(err), 32'd0);
        exp_iss.delete();
        exp_res.delete();
        rst_n = 1'b1;
    endtask

    // AD7928-like engine: data returned in a frame belongs to the previous frame's address.
    initial begin
        frm_busy = 1'b0; frm_done = 1'b0; frm_data = '0;
        eng_act = 1'b0; eng_cnt = 0; cur_ch = '0; last_ch = '0;
        start_no = 0; done_no = 0;
        forever begin
            @(posedge clk);
            #1;
            frm_done = 1'b0;
            if (!rst_n) begin
                eng_act = 1'b0; frm_busy = 1'b0; last_ch = '0;
                start_no = 0; done_no = 0;
            end else if (eng_act) begin
                if (eng_cnt == 0) begin
                    done_no++;
                    tag = (done_no == corrupt_at) ? 3'd5 : last_ch;
                    frm_data = {1'b0, tag, VAL[last_ch]};
                    frm_done = 1'b1;
                    frm_busy = 1'b0;
                    eng_act  = 1'b0;
                    last_ch  = cur_ch;
                end else begin
                    eng_cnt--;
                end
            end else if (frm_start) begin
                start_no++;
                eng_act  = 1'b1;
                eng_cnt  = FRAME_LEN;
                frm_busy = 1'b1;
                cur_ch   = frm_addr;
                if (start_no == glitch_at) begin
                    frm_done = 1'b1;
                    frm_data = 16'h0FFF;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues a frame or returns a result.
    initial begin
        logic [2:0] ea;
        res_t       er;
        logic [7:0] oh;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frm_start) begin
                    if (exp_iss.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_issue: got frm_addr %0d, expected no frame", frm_addr);
                    end else begin
                        ea = exp_iss.pop_front();
                        chk("issue_addr", 32'(frm_addr), 32'(ea));
                    end
                end
                if (res_vld) begin
                    if (exp_res.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_result: got ch %0d data %0h, expected none", res_ch, res_data);
                    end else begin
                        er = exp_res.pop_front();
                        oh = 8'h01 << er.ch;
                        chk("res_ch", 32'(res_ch), 32'(er.ch));
                        chk("res_data", 32'(res_data), 32'(er.d));
                        chk("res_ack", 32'(ack), 32'(oh));
                    end
                end else if (ack != '0) begin
                    n_vec++; n_bad++;
                    $display("FAIL stray_ack: got %0h, expected 0", ack);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req = '0; scan_en = 1'b0; scan_mask = '0; err_clr = 1'b0;
        glitch_at = 0; corrupt_at = 0;

        // single request: real frame for ch3, flush frame returns 0x3ABC
        do_reset("single");
        exp_iss.push_back(3'd3); exp_iss.push_back(3'd3);
        push_res(3'd3);
        pulse_req(8'h08);
        wait_drain("single");

        // simultaneous ch0+ch7; stale done coincident with frame 2 start must be ignored
        do_reset("simul");
        glitch_at = 2;
        exp_iss.push_back(3'd0); exp_iss.push_back(3'd7); exp_iss.push_back(3'd7);
        push_res(3'd0); push_res(3'd7);
        pulse_req(8'h81);
        wait_drain("simul");

        // round-robin fairness with retoggled requests
        do_reset("rr");
        exp_iss.push_back(3'd0); exp_iss.push_back(3'd1); exp_iss.push_back(3'd0);
        exp_iss.push_back(3'd1); exp_iss.push_back(3'd1);
        push_res(3'd0); push_res(3'd1); push_res(3'd0); push_res(3'd1);
        pulse_req(8'h03);
        wait_start("rr1");
        pulse_req(8'h01);
        wait_start("rr2");
        pulse_req(8'h02);
        wait_drain("rr");

        // auto-scan: two rounds 100 cycles apart, none after scan_en drops
        do_reset("scan");
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) exp_iss.push_back(3'(c));
            exp_iss.push_back(3'd3);
            for (int c = 0; c < 4; c++) push_res(3'(c));
        end
        scan_mask = 8'h0F;
        scan_en   = 1'b1;
        repeat (90) @(negedge clk);
        chk("scan_before_tick", 32'(exp_iss.size()), 32'd10);
        repeat (80) @(negedge clk);
        chk("scan_round1_iss", 32'(exp_iss.size()), 32'd5);
        chk("scan_round1_res", 32'(exp_res.size()), 32'd4);
        repeat (90) @(negedge clk);
        scan_en = 1'b0;
        repeat (200) @(negedge clk);
        wait_drain("scan");

        // returned address tag corrupted on the ch3 result frame
        do_reset("tag");
        corrupt_at = 2;
`ifdef ADC_SEQ_SCHED_TAG_CHECK_EN
        for (int i = 0; i < 4; i++) exp_iss.push_back(3'd3);
        push_res(3'd3);
        pulse_req(8'h08);
        wait_drain("tag");
        chk("tag_err_set", 32'(err), 32'd1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("tag_err_clr", 32'(err), 32'd0);
`else
        exp_iss.push_back(3'd3); exp_iss.push_back(3'd3);
        push_res(3'd3);
        pulse_req(8'h08);
        wait_drain("tag");
        chk("tag_err_tied", 32'(err), 32'd0);
`endif

        // reset in the middle of a frame drops the outstanding conversion
        do_reset("midrst_pre");
        exp_iss.push_back(3'd3);
        pulse_req(8'h08);
        wait_start("midrst");
        repeat (2) @(negedge clk);
        do_reset("midrst");
        exp_iss.push_back(3'd5); exp_iss.push_back(3'd5);
        push_res(3'd5);
        pulse_req(8'h20);
        wait_drain("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
